mb_sata_bridge: RTL and testbench
=================================

# mb_sata_bridge

Parametrised register-mapped bridge between the MicroBlaze IP bus (MB2IP/IP2MB) and the SATA wrapper user port. It replaces ad-hoc test glue with a configurable command engine. The engine has programmable address, word count and DATA_W-wide TX/RX FIFOs of configurable depth, plus a stretched SATA controller reset pulse. It sits between the MicroBlaze system and SATA_WRAPPER in the test top.

## Interface
- DATA_W, 32: MB and SATA data width.
- SATA_ADDR_W, 57: SATA ADDRESS_IN width (33..64).
- FIFO_DEPTH, 16: TX and RX FIFO depth in words; power of 2, ≥4.
- CNT_W, 16: transfer word-count width.
- RST_CYCLES, 64: SATA_CTRL_RESET_OUT pulse length in clocks (≥1).
- MB_CLK  in  1  single clock; the MB bus and SATA user port are synchronous to it.
- MB_RESET_N  in  1  asynchronous, active-low reset.
- MB_ADDR  in  32  byte address; bits [5:2] decoded.
- MB_CS / MB_RNW  in  1/1  access strobe, held until acked; 1 = read.
- MB_WDATA / MB_RDATA  in/out  DATA_W  bus write and read data.
- MB_RD_ACK / MB_WR_ACK  out  1  one-cycle acks.
- SATA_WR_EN / SATA_RD_EN  out  1  transfer enables.
- SATA_ADDR  out  SATA_ADDR_W  transfer start address.
- SATA_WDATA  out  DATA_W  write beat data, driven from the TX FIFO head.
- SATA_RDATA  in  DATA_W  read beat data.
- SATA_WR_HOLD / SATA_RD_HOLD  in  1  backpressure: no beat transfers while high.
- SATA_WR_DONE  in  1  pulse when the device completes the write.
- SATA_CTRL_RESET_OUT  out  1  active-high reset to SATA_WRAPPER.

## Operation
- Register map (offset):
  - 0x00 CTRL, write-only: bit0 START_WR, bit1 START_RD, bit2 SATA_RST, bit3 CLR_ERR.
  - 0x04 ADDR_LO.
  - 0x08 ADDR_HI, bits [SATA_ADDR_W-33:0].
  - 0x0C COUNT, CNT_W bits, unit is words.
  - 0x10 DATA: a write pushes the TX FIFO; a read pops the RX FIFO.
  - 0x14 STATUS: bit0 BUSY, bit1 DONE (sticky, cleared by START), bit2 START_WHILE_BUSY err, bit3 RX underflow err, [15:8] TX level, [23:16] RX level.
  - 0x18 PERF (see Configuration).
  - Other offsets read 0; writes to them are acked and ignored.
- Bus handshake:
  - An access is acked once, one cycle after MB_CS is first seen high.
  - No re-ack occurs until MB_CS drops.
  - A DATA write while the TX FIFO is full holds off MB_WR_ACK until space exists.
  - A DATA read while the RX FIFO is empty acks immediately with 0 and sets the underflow err.
- FSM states: IDLE, WRITE, WAIT_DONE, READ, RST.
  - IDLE→WRITE on START_WR. IDLE→READ on START_RD. IDLE→RST on SATA_RST.
  - START with COUNT=0: sets DONE and stays in IDLE; no beats.
  - Any START or SATA_RST outside IDLE is ignored and sets START_WHILE_BUSY err.
  - START_WR and START_RD together: START_WR wins.
- WRITE:
  - SATA_WR_EN=1 while remaining>0 and the TX FIFO is non-empty.
  - A beat is accepted when SATA_WR_EN & !SATA_WR_HOLD; it pops TX and decrements remaining.
  - remaining→0 moves to WAIT_DONE with SATA_WR_EN deasserted.
  - SATA_WR_DONE in WAIT_DONE → IDLE and sets DONE.
- READ:
  - SATA_RD_EN=1 while remaining>0 and the RX FIFO is not full.
  - An accepted beat (SATA_RD_EN & !SATA_RD_HOLD) pushes SATA_RDATA and decrements remaining.
  - remaining→0 → IDLE and sets DONE.
- RST: SATA_CTRL_RESET_OUT held high exactly RST_CYCLES clocks, then → IDLE. The FIFOs are flushed on RST entry.
- SATA_ADDR is latched from ADDR_HI:ADDR_LO at START and is stable for the whole transfer.

## Timing
- Reset values:
  - MB_RD_ACK, MB_WR_ACK, SATA_WR_EN, SATA_RD_EN, SATA_CTRL_RESET_OUT all 0.
  - MB_RDATA, SATA_ADDR, SATA_WDATA all 0.
  - FIFOs empty, FSM in IDLE, STATUS 0.
- Ack latency: 1 cycle after CS for all accesses except a TX-full hold-off. MB_RDATA is valid in the ack cycle.
- The first SATA_WR_EN is registered: it asserts 1 cycle after START_WR is acked if TX is non-empty.
- TX FIFO: a push and a pop in the same cycle are both honoured, with the level unchanged.
- RX FIFO: a bus pop and a SATA push in the same cycle are both honoured.
- The RX-full check uses the post-pop level, so there is no overflow and no bubble at full.
- An asynchronous reset mid-transfer aborts immediately. All outputs go to their reset values, with no partial-state retention.

## Configuration
- MB_SATA_BRIDGE_PERF_EN defined: PERF at 0x18 is a 32-bit saturating counter.
  - It counts cycles with BUSY=1 and a HOLD asserted.
  - It is cleared at START and by CLR_ERR.
- MB_SATA_BRIDGE_PERF_EN undefined: the counter is absent and 0x18 reads 0.

## Test plan
- Write transfer:
  - Stimulus: ADDR=0x1_0000_0100, COUNT=8, push 8 words 0xA0..0xA7, START_WR, WR_HOLD low.
  - Response: 8 consecutive beats with SATA_ADDR=0x1_0000_0100; after a WR_DONE pulse, STATUS=0x2.
- Read with backpressure:
  - Stimulus: COUNT=20, FIFO_DEPTH=16, no bus pops for 40 cycles, RD_HOLD toggling.
  - Response: RD_EN drops at RX level 16. After 20 DATA reads the data is in order and DONE is set.
- TX full:
  - Stimulus: 17 DATA writes with no transfer running.
  - Response: the 17th MB_WR_ACK is withheld until a START_WR with COUNT≥1 pops a beat.
- Underflow and busy error:
  - Stimulus: a DATA read when RX is empty; then START_RD issued while in READ.
  - Response: rdata 0, STATUS bits 3 and 2 set; CLR_ERR clears both.
- SATA reset pulse:
  - Stimulus: CTRL=0x4.
  - Response: SATA_CTRL_RESET_OUT high for exactly 64 cycles, FIFOs empty.
  - Stimulus: MB_RESET_N low mid-READ.
  - Response: all outputs 0 immediately.
- Zero count:
  - Stimulus: COUNT=0, START_WR.
  - Response: no SATA_WR_EN; DONE set next cycle.
  - With MB_SATA_BRIDGE_PERF_EN defined, PERF=0.

Source files
------------

// File: rtl/mb_sata_bridge.sv
// mb_sata_bridge: register-mapped command engine between the MicroBlaze IP
// bus and the SATA wrapper user port. Holds programmable start address,
// word count, TX/RX data FIFOs and a stretched SATA controller reset.
//
// Optional feature macro: MB_SATA_BRIDGE_PERF_EN
//   defined   -> 0x18 PERF is a 32-bit saturating count of busy cycles with a
//                HOLD asserted, cleared at START and by CLR_ERR.
//   undefined -> no counter, 0x18 reads 0.
//
// Bus handshake (valid/ready view): MB_CS is the request valid, held by the
// master until it sees MB_RD_ACK/MB_WR_ACK. The bridge accepts an access on
// the first clock edge where CS is high and it is able to complete it; the
// ack is a registered one-cycle pulse in the following cycle, and no further
// access is accepted until CS has been seen low. A DATA write that meets a
// full TX FIFO is simply not accepted until space exists (or a beat pops in
// the same cycle).
//
// Commands written to CTRL are registered first and acted on by the FSM one
// cycle later, so the SATA enables follow the START ack by one cycle.

module mb_sata_bridge #(
   parameter int DATA_W      = 32,
   parameter int SATA_ADDR_W = 57,
   parameter int FIFO_DEPTH  = 16,
   parameter int CNT_W       = 16,
   parameter int RST_CYCLES  = 64
) (
   input  logic                   MB_CLK,
   input  logic                   MB_RESET_N,
   input  logic [31:0]            MB_ADDR,
   input  logic                   MB_CS,
   input  logic                   MB_RNW,
   input  logic [DATA_W-1:0]      MB_WDATA,
   output logic [DATA_W-1:0]      MB_RDATA,
   output logic                   MB_RD_ACK,
   output logic                   MB_WR_ACK,
   output logic                   SATA_WR_EN,
   output logic                   SATA_RD_EN,
   output logic [SATA_ADDR_W-1:0] SATA_ADDR,
   output logic [DATA_W-1:0]      SATA_WDATA,
   input  logic [DATA_W-1:0]      SATA_RDATA,
   input  logic                   SATA_WR_HOLD,
   input  logic                   SATA_RD_HOLD,
   input  logic                   SATA_WR_DONE,
   output logic                   SATA_CTRL_RESET_OUT,
   output logic [2:0]             dbg_state
);

   localparam int AW  = $clog2(FIFO_DEPTH);
   localparam int LW  = AW + 1;
   localparam int AHW = SATA_ADDR_W - 32;
   localparam int RCW = $clog2(RST_CYCLES) + 1;

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WRITE     = 3'd1;
   localparam logic [2:0] S_WAIT_DONE = 3'd2;
   localparam logic [2:0] S_READ      = 3'd3;
   localparam logic [2:0] S_RST       = 3'd4;

   logic [2:0]        state;
   logic [31:0]       addr_lo;
   logic [AHW-1:0]    addr_hi;
   logic [CNT_W-1:0]  count_reg;
   logic [CNT_W-1:0]  remaining;
   logic              cmd_wr_q, cmd_rd_q, cmd_rst_q;
   logic              acc_done;
   logic              done, err_busy, err_under;
   logic [RCW-1:0]    rst_cnt;

   logic [DATA_W-1:0] tx_mem [FIFO_DEPTH];
   logic [DATA_W-1:0] rx_mem [FIFO_DEPTH];
   logic [LW-1:0]     tx_wp, tx_rp, tx_level;
   logic [LW-1:0]     rx_wp, rx_rp, rx_level, rx_post;
   logic              tx_full, tx_empty, tx_push, tx_pop;
   logic              rx_full_post, rx_empty, rx_push, rx_pop;

   logic [3:0]        sel;
   logic              bus_go, is_data, wr_accept, rd_accept, underflow;
   logic              ctrl_wr, clr_err, busy;
   logic              start_wr_go, start_rd_go, rst_go, busy_cmd_err;
   logic [DATA_W-1:0] rd_val;
   logic [31:0]       perf_val;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^{MB_ADDR[31:6], MB_ADDR[1:0]};
   assign dbg_state        = state;

   // Bus decode, FIFO status and SATA-side enables.
   always_comb begin
      sel          = MB_ADDR[5:2];
      is_data      = (sel == 4'd4);
      bus_go       = MB_CS & ~acc_done;
      busy         = (state != S_IDLE);

      tx_level     = tx_wp - tx_rp;
      tx_empty     = (tx_level == '0);
      tx_full      = (tx_level == LW'(FIFO_DEPTH));
      rx_level     = rx_wp - rx_rp;
      rx_empty     = (rx_level == '0);

      SATA_WR_EN   = (state == S_WRITE) && (remaining != '0) && !tx_empty;
      tx_pop       = SATA_WR_EN & ~SATA_WR_HOLD;
      tx_push      = bus_go & ~MB_RNW & is_data & (~tx_full | tx_pop);
      wr_accept    = bus_go & ~MB_RNW & (~is_data | ~tx_full | tx_pop);
      rd_accept    = bus_go & MB_RNW;
      rx_pop       = rd_accept & is_data & ~rx_empty;
      underflow    = rd_accept & is_data & rx_empty;

      // Full check on the level after this cycle's bus pop, so a pop at
      // full lets a beat in during the same cycle.
      rx_post      = rx_level - LW'(rx_pop);
      rx_full_post = (rx_post == LW'(FIFO_DEPTH));
      SATA_RD_EN   = (state == S_READ) && (remaining != '0) && !rx_full_post;
      rx_push      = SATA_RD_EN & ~SATA_RD_HOLD;

      ctrl_wr      = wr_accept & (sel == 4'd0);
      clr_err      = ctrl_wr & MB_WDATA[3];
      start_wr_go  = (state == S_IDLE) & cmd_wr_q;
      start_rd_go  = (state == S_IDLE) & cmd_rd_q & ~cmd_wr_q;
      rst_go       = (state == S_IDLE) & cmd_rst_q & ~cmd_wr_q & ~cmd_rd_q;
      busy_cmd_err = (state != S_IDLE) & (cmd_wr_q | cmd_rd_q | cmd_rst_q);

      SATA_CTRL_RESET_OUT = (state == S_RST);
      SATA_WDATA   = tx_empty ? '0 : tx_mem[tx_rp[AW-1:0]];
   end

   // Register read multiplexer.
   always_comb begin
      rd_val = '0;
      case (sel)
         4'd1: rd_val[31:0]      = addr_lo;
         4'd2: rd_val[AHW-1:0]   = addr_hi;
         4'd3: rd_val[CNT_W-1:0] = count_reg;
         4'd4: if (!rx_empty) rd_val = rx_mem[rx_rp[AW-1:0]];
         4'd5: rd_val[23:0]      = {8'(rx_level), 8'(tx_level), 4'b0000,
                                    err_under, err_busy, done, busy};
         4'd6: rd_val[31:0]      = perf_val;
         default: ;
      endcase
   end

   // Bus slave: acks, read data, config registers and command capture.
   always_ff @(posedge MB_CLK or negedge MB_RESET_N) begin
      if (!MB_RESET_N) begin
         MB_WR_ACK <= 1'b0;
         MB_RD_ACK <= 1'b0;
         MB_RDATA  <= '0;
         acc_done  <= 1'b0;
         addr_lo   <= '0;
         addr_hi   <= '0;
         count_reg <= '0;
         cmd_wr_q  <= 1'b0;
         cmd_rd_q  <= 1'b0;
         cmd_rst_q <= 1'b0;
      end else begin
         MB_WR_ACK <= wr_accept;
         MB_RD_ACK <= rd_accept;
         if (wr_accept || rd_accept) acc_done <= 1'b1;
         else if (!MB_CS)            acc_done <= 1'b0;
         if (rd_accept) MB_RDATA <= rd_val;
         cmd_wr_q  <= ctrl_wr & MB_WDATA[0];
         cmd_rd_q  <= ctrl_wr & MB_WDATA[1];
         cmd_rst_q <= ctrl_wr & MB_WDATA[2];
         if (wr_accept) begin
            case (sel)
               4'd1: addr_lo   <= MB_WDATA[31:0];
               4'd2: addr_hi   <= MB_WDATA[AHW-1:0];
               4'd3: count_reg <= MB_WDATA[CNT_W-1:0];
               default: ;
            endcase
         end
      end
   end

   // Command FSM with remaining count, latched address and status flags.
   always_ff @(posedge MB_CLK or negedge MB_RESET_N) begin
      if (!MB_RESET_N) begin
         state     <= S_IDLE;
         remaining <= '0;
         SATA_ADDR <= '0;
         done      <= 1'b0;
         err_busy  <= 1'b0;
         err_under <= 1'b0;
         rst_cnt   <= '0;
      end else begin
         if (clr_err) begin
            err_busy  <= 1'b0;
            err_under <= 1'b0;
         end
         if (underflow)    err_under <= 1'b1;
         if (busy_cmd_err) err_busy  <= 1'b1;
         case (state)
            S_IDLE: begin
               if (start_wr_go || start_rd_go) begin
                  SATA_ADDR <= {addr_hi, addr_lo};
                  remaining <= count_reg;
                  if (count_reg == '0) begin
                     done <= 1'b1;
                  end else begin
                     done  <= 1'b0;
                     state <= start_wr_go ? S_WRITE : S_READ;
                  end
               end else if (rst_go) begin
                  state   <= S_RST;
                  rst_cnt <= '0;
               end
            end
            S_WRITE: begin
               if (tx_pop) begin
                  remaining <= remaining - 1'b1;
                  if (remaining == CNT_W'(1)) state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (SATA_WR_DONE) begin
                  state <= S_IDLE;
                  done  <= 1'b1;
               end
            end
            S_READ: begin
               if (rx_push) begin
                  remaining <= remaining - 1'b1;
                  if (remaining == CNT_W'(1)) begin
                     state <= S_IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            S_RST: begin
               if (rst_cnt == RCW'(RST_CYCLES - 1)) state <= S_IDLE;
               else                                  rst_cnt <= rst_cnt + 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // TX FIFO pointers; flushed when the SATA reset sequence starts.
   always_ff @(posedge MB_CLK or negedge MB_RESET_N) begin
      if (!MB_RESET_N) begin
         tx_wp <= '0;
         tx_rp <= '0;
      end else if (rst_go) begin
         tx_wp <= '0;
         tx_rp <= '0;
      end else begin
         if (tx_push) tx_wp <= tx_wp + 1'b1;
         if (tx_pop)  tx_rp <= tx_rp + 1'b1;
      end
   end

   // TX FIFO storage, written from the bus.
   always_ff @(posedge MB_CLK) begin
      if (tx_push) tx_mem[tx_wp[AW-1:0]] <= MB_WDATA;
   end

   // RX FIFO pointers; flushed when the SATA reset sequence starts.
   always_ff @(posedge MB_CLK or negedge MB_RESET_N) begin
      if (!MB_RESET_N) begin
         rx_wp <= '0;
         rx_rp <= '0;
      end else if (rst_go) begin
         rx_wp <= '0;
         rx_rp <= '0;
      end else begin
         if (rx_push) rx_wp <= rx_wp + 1'b1;
         if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      end
   end

   // RX FIFO storage, written from the SATA read beats.
   always_ff @(posedge MB_CLK) begin
      if (rx_push) rx_mem[rx_wp[AW-1:0]] <= SATA_RDATA;
   end

`ifdef MB_SATA_BRIDGE_PERF_EN
   logic [31:0] perf_cnt;

   // Saturating count of busy cycles stalled by either HOLD.
   always_ff @(posedge MB_CLK or negedge MB_RESET_N) begin
      if (!MB_RESET_N)                             perf_cnt <= '0;
      else if (start_wr_go || start_rd_go || clr_err) perf_cnt <= '0;
      else if (busy && (SATA_WR_HOLD || SATA_RD_HOLD) && (perf_cnt != 32'hFFFF_FFFF))
         perf_cnt <= perf_cnt + 1'b1;
   end

   assign perf_val = perf_cnt;
`else
   assign perf_val = '0;
`endif

endmodule

// File: tb/tb_mb_sata_bridge.sv
// Bench for mb_sata_bridge: register vector table plus directed transfer,
// backpressure, FIFO-full, error, SATA reset and async reset sequences.

module tb_mb_sata_bridge;

   logic        MB_CLK = 1'b0;
   logic        MB_RESET_N;
   logic [31:0] MB_ADDR;
   logic        MB_CS, MB_RNW;
   logic [31:0] MB_WDATA, MB_RDATA;
   logic        MB_RD_ACK, MB_WR_ACK;
   logic        SATA_WR_EN, SATA_RD_EN;
   logic [56:0] SATA_ADDR;
   logic [31:0] SATA_WDATA, SATA_RDATA;
   logic        SATA_WR_HOLD, SATA_RD_HOLD, SATA_WR_DONE;
   logic        SATA_CTRL_RESET_OUT;
   logic [2:0]  dbg_state;

   int n_cmp  = 0;
   int n_fail = 0;
   int rbeats = 0;
   logic [31:0] exp_q[$];

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] exp;
   } vec_t;
   vec_t vecs[14];

   mb_sata_bridge dut (
      .MB_CLK(MB_CLK), .MB_RESET_N(MB_RESET_N), .MB_ADDR(MB_ADDR),
      .MB_CS(MB_CS), .MB_RNW(MB_RNW), .MB_WDATA(MB_WDATA), .MB_RDATA(MB_RDATA),
      .MB_RD_ACK(MB_RD_ACK), .MB_WR_ACK(MB_WR_ACK),
      .SATA_WR_EN(SATA_WR_EN), .SATA_RD_EN(SATA_RD_EN), .SATA_ADDR(SATA_ADDR),
      .SATA_WDATA(SATA_WDATA), .SATA_RDATA(SATA_RDATA),
      .SATA_WR_HOLD(SATA_WR_HOLD), .SATA_RD_HOLD(SATA_RD_HOLD),
      .SATA_WR_DONE(SATA_WR_DONE), .SATA_CTRL_RESET_OUT(SATA_CTRL_RESET_OUT),
      .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 MB_CLK = ~MB_CLK;

   // ---------------- scoreboard / checker ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                            input int budget, output int cyc);
      @(negedge MB_CLK);
      MB_CS = 1'b1; MB_RNW = 1'b0; MB_ADDR = a; MB_WDATA = d;
      cyc = -1;
      for (int i = 1; i <= budget; i++) begin
         @(negedge MB_CLK);
         if (MB_WR_ACK) begin
            cyc = i;
            break;
         end
      end
      MB_CS = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] a, input int budget,
                           output logic [31:0] d, output int cyc);
      @(negedge MB_CLK);
      MB_CS = 1'b1; MB_RNW = 1'b1; MB_ADDR = a;
      cyc = -1;
      d   = 32'hX;
      for (int i = 1; i <= budget; i++) begin
         @(negedge MB_CLK);
         if (MB_RD_ACK) begin
            cyc = i;
            d   = MB_RDATA;
            break;
         end
      end
      MB_CS = 1'b0;
   endtask

   task automatic wr_reg(input string name, input logic [31:0] a, input logic [31:0] d);
      int cyc;
      bus_write(a, d, 8, cyc);
      check({name, "_ack"}, cyc, 1);
   endtask

   task automatic rd_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
      int cyc;
      logic [31:0] d;
      bus_read(a, 8, d, cyc);
      check({name, "_ack"}, cyc, 1);
      check(name, d, exp);
   endtask

   task automatic wr_done_pulse();
      @(negedge MB_CLK); SATA_WR_DONE = 1'b1;
      @(negedge MB_CLK); SATA_WR_DONE = 1'b0;
   endtask

   // One SATA read-side cycle: toggling hold, data tagged by beat number.
   task automatic rd_feed_cycle(input int i);
      @(negedge MB_CLK);
      SATA_RD_HOLD = (i % 2 == 1);
      SATA_RDATA   = 32'hB00 + rbeats;
      #1;
      if (SATA_RD_EN && !SATA_RD_HOLD) begin
         exp_q.push_back(SATA_RDATA);
         rbeats++;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int cyc, beats, first, last, acks, hi_cnt, en_cnt;
      logic [31:0] d, e;
      logic seen_hi;

      MB_RESET_N = 1'b0; MB_ADDR = '0; MB_CS = 1'b0; MB_RNW = 1'b0; MB_WDATA = '0;
      SATA_RDATA = '0; SATA_WR_HOLD = 1'b0; SATA_RD_HOLD = 1'b0; SATA_WR_DONE = 1'b0;

      vecs[0]  = '{1'b0, 32'h14, 32'h0,         32'h0};
      vecs[1]  = '{1'b0, 32'h04, 32'h0,         32'h0};
      vecs[2]  = '{1'b1, 32'h04, 32'h0000_0100, 32'h0};
      vecs[3]  = '{1'b0, 32'h04, 32'h0,         32'h0000_0100};
      vecs[4]  = '{1'b1, 32'h08, 32'hFFFF_FFFF, 32'h0};
      vecs[5]  = '{1'b0, 32'h08, 32'h0,         32'h01FF_FFFF};
      vecs[6]  = '{1'b1, 32'h08, 32'h0000_0001, 32'h0};
      vecs[7]  = '{1'b0, 32'h08, 32'h0,         32'h0000_0001};
      vecs[8]  = '{1'b1, 32'h0C, 32'h0003_0008, 32'h0};
      vecs[9]  = '{1'b0, 32'h0C, 32'h0,         32'h0000_0008};
      vecs[10] = '{1'b0, 32'h00, 32'h0,         32'h0};
      vecs[11] = '{1'b0, 32'h18, 32'h0,         32'h0};
      vecs[12] = '{1'b1, 32'h1C, 32'h0000_DEAD, 32'h0};
      vecs[13] = '{1'b0, 32'h04, 32'h0,         32'h0000_0100};

      // reset state
      repeat (3) @(negedge MB_CLK);
      check("rst_ctl_outs", {MB_RD_ACK, MB_WR_ACK, SATA_WR_EN, SATA_RD_EN, SATA_CTRL_RESET_OUT}, 0);
      check("rst_rdata", MB_RDATA, 0);
      check("rst_sata_addr", SATA_ADDR, 0);
      check("rst_wdata", SATA_WDATA, 0);
      check("rst_state", dbg_state, 0);
      MB_RESET_N = 1'b1;

      // register vector table
      for (int i = 0; i < 14; i++) begin
         if (vecs[i].wr) begin
            bus_write(vecs[i].addr, vecs[i].data, 8, cyc);
            check($sformatf("vec%0d_ack", i), cyc, 1);
         end else begin
            bus_read(vecs[i].addr, 8, d, cyc);
            check($sformatf("vec%0d_ack", i), cyc, 1);
            check($sformatf("vec%0d_data", i), d, vecs[i].exp);
         end
      end

      // CS held long after ack: exactly one ack
      @(negedge MB_CLK);
      MB_CS = 1'b1; MB_RNW = 1'b1; MB_ADDR = 32'h04;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge MB_CLK);
         if (MB_RD_ACK) acks++;
      end
      MB_CS = 1'b0;
      check("single_ack", acks, 1);

      // write transfer: 8 words to 0x1_0000_0100
      for (int i = 0; i < 8; i++) begin
         wr_reg("tx_push", 32'h10, 32'hA0 + i);
         exp_q.push_back(32'hA0 + i);
      end
      rd_reg("status_tx8", 32'h14, 32'h0000_0800);
      wr_reg("start_wr", 32'h00, 32'h1);
      beats = 0; first = -1; last = -1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge MB_CLK);
         if (SATA_WR_EN) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else e = 32'hDEAD_BEEF;
            check("wr_beat_data", SATA_WDATA, e);
            if (first < 0) begin
               first = i;
               check("wr_first_addr", SATA_ADDR, 57'h1_0000_0100);
            end
            last = i;
            beats++;
         end
      end
      check("wr_beats", beats, 8);
      check("wr_first_cycle", first, 1);
      check("wr_last_cycle", last, 8);
      check("wr_addr_stable", SATA_ADDR, 57'h1_0000_0100);
      check("wr_wait_done_state", dbg_state, 2);
      wr_done_pulse();
      rd_reg("status_wr_done", 32'h14, 32'h0000_0002);

      // read with backpressure: 20 words into a 16-deep RX
      exp_q.delete();
      rbeats = 0;
      wr_reg("count20", 32'h0C, 32'd20);
      wr_reg("start_rd", 32'h00, 32'h2);
      for (int i = 1; i <= 40; i++) rd_feed_cycle(i);
      check("rd_beats_at_full", rbeats, 16);
      check("rd_en_low_at_full", SATA_RD_EN, 0);
      rd_reg("status_rx16", 32'h14, 32'h0010_0001);
      fork
         begin
            for (int k = 0; k < 20; k++) begin
               bus_read(32'h10, 8, d, cyc);
               if (exp_q.size() > 0) e = exp_q.pop_front();
               else e = 32'hDEAD_BEEF;
               check($sformatf("rd_data%0d", k), d, e);
            end
         end
         begin
            for (int i = 41; i <= 240 && rbeats < 20; i++) rd_feed_cycle(i);
         end
      join
      SATA_RD_HOLD = 1'b0;
      check("rd_beats_total", rbeats, 20);
      rd_reg("status_rd_done", 32'h14, 32'h0000_0002);

      // TX full: 17th write withheld until a beat pops
      for (int i = 0; i < 16; i++) wr_reg("fill", 32'h10, 32'hC0 + i);
      bus_write(32'h10, 32'hD0, 10, cyc);
      check("tx_full_no_ack", cyc, -1);
      wr_reg("count1", 32'h0C, 32'd1);
      SATA_WR_HOLD = 1'b1;
      wr_reg("start_wr1", 32'h00, 32'h1);
      fork
         bus_write(32'h10, 32'hD0, 20, cyc);
         begin
            repeat (5) @(negedge MB_CLK);
            check("tx_head_w0", SATA_WDATA, 32'hC0);
            SATA_WR_HOLD = 1'b0;
         end
      join
      check("tx_full_ack_after_pop", cyc, 5);
      wr_done_pulse();
      rd_reg("status_tx16", 32'h14, 32'h0000_1002);

      // SATA reset pulse
      wr_reg("sata_rst", 32'h00, 32'h4);
      hi_cnt = 0; seen_hi = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge MB_CLK);
         if (SATA_CTRL_RESET_OUT) begin
            hi_cnt++;
            seen_hi = 1'b1;
         end else if (seen_hi) begin
            break;
         end
      end
      check("rst_pulse_len", hi_cnt, 64);
      rd_reg("status_after_rst", 32'h14, 32'h0000_0002);

      // underflow and start-while-busy errors
      rd_reg("underflow_rdata", 32'h10, 32'h0);
      wr_reg("count4", 32'h0C, 32'd4);
      SATA_RD_HOLD = 1'b1;
      wr_reg("start_rd_a", 32'h00, 32'h2);
      wr_reg("start_rd_b", 32'h00, 32'h2);
      rd_reg("status_errs", 32'h14, 32'h0000_000D);
      wr_reg("clr_err", 32'h00, 32'h8);
      rd_reg("status_clr", 32'h14, 32'h0000_0001);

      // asynchronous reset mid-READ
      @(negedge MB_CLK);
      check("rd_en_before_reset", SATA_RD_EN, 1);
      MB_RESET_N = 1'b0;
      #1;
      check("arst_ctl_outs", {MB_RD_ACK, MB_WR_ACK, SATA_WR_EN, SATA_RD_EN, SATA_CTRL_RESET_OUT}, 0);
      check("arst_rdata", MB_RDATA, 0);
      check("arst_sata_addr", SATA_ADDR, 0);
      check("arst_wdata", SATA_WDATA, 0);
      check("arst_state", dbg_state, 0);
      @(negedge MB_CLK);
      MB_RESET_N = 1'b1;
      SATA_RD_HOLD = 1'b0;
      rd_reg("status_after_arst", 32'h14, 32'h0);

      // zero count start
      wr_reg("count0", 32'h0C, 32'd0);
      wr_reg("start_wr0", 32'h00, 32'h1);
      en_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge MB_CLK);
         if (SATA_WR_EN) en_cnt++;
      end
      check("zero_cnt_no_wr_en", en_cnt, 0);
      check("zero_cnt_idle", dbg_state, 0);
      rd_reg("status_zero_done", 32'h14, 32'h0000_0002);

      // final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
